unified_block_memory: RTL and testbench

UNIFIED_BLOCK_MEMORY -- requirements
Module: unified_block_memory

---
 rtl/unified_block_memory.sv | 206 ++++++++++++++++++++
 tb/tb_unified_block_memory.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_block_memory.sv
// unified_block_memory
//   Shared block memory serving an instruction read port and a data
//   read/write port. One request at a time is in flight. Each request
//   completes a fixed LATENCY cycles after it is accepted, and completion
//   is signalled by a one-cycle pulse on the requesting port.
//
// Parameters
//   BLOCK_BITS  width of one block (both sides)
//   ADDR_BITS   block address width, depth = 2**ADDR_BITS
//   LATENCY     acceptance-to-pulse distance in cycles, 1..255
//
// Ports
//   clock, reset                 single clock, synchronous active-high reset
//   ImemRen / IblockAddr         instruction read request (level) and address
//   ImemDout / ImemReadReady     instruction read data and completion pulse
//   DmemRen / DmemWen            data read / write requests (level)
//   DblockAddress / DmemDin      data address and write block
//   DmemDout / DmemReadReady     data read data and completion pulse
//   DmemWriteDone                data write completion pulse
//
// FSM states
//   state | meaning
//   IDLE  | arbitrate pending requests (write > data read > instr read)
//   BUSY  | latency countdown, abort if the in-flight request drops
//   DONE  | one cycle of completion pulse; a write commits on this edge

module unified_block_memory #(
    parameter int BLOCK_BITS = 128,
    parameter int ADDR_BITS  = 10,
    parameter int LATENCY    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ImemRen,
    input  logic [ADDR_BITS-1:0]  IblockAddr,
    output logic [BLOCK_BITS-1:0] ImemDout,
    output logic                  ImemReadReady,
    input  logic                  DmemRen,
    input  logic                  DmemWen,
    input  logic [ADDR_BITS-1:0]  DblockAddress,
    input  logic [BLOCK_BITS-1:0] DmemDin,
    output logic [BLOCK_BITS-1:0] DmemDout,
    output logic                  DmemReadReady,
    output logic                  DmemWriteDone
);

    localparam int         DEPTH      = 2 ** ADDR_BITS;
    localparam logic [7:0] COUNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [7:0]            r_count;
    logic [ADDR_BITS-1:0]  r_addr;
    logic                  r_write;
    logic                  r_data_port;
    logic [BLOCK_BITS-1:0] r_wdata;
    logic                  r_served_i;
    logic                  r_served_d;
    logic [BLOCK_BITS-1:0] r_imem_dout;
    logic [BLOCK_BITS-1:0] r_dmem_dout;
    logic                  r_imem_rdy;
    logic                  r_dmem_rdy;
    logic                  r_dmem_wdone;
    logic [BLOCK_BITS-1:0] r_mem [0:DEPTH-1];

    logic                  w_accept;
    logic                  w_acc_write;
    logic                  w_acc_data;
    logic                  w_complete;
    logic                  w_req_held;
    logic                  w_d_elig;

    // The in-flight request must stay asserted in the direction that was
    // latched; a write whose Wen drops while Ren is still high is aborted.
    assign w_req_held = r_data_port ? (r_write ? DmemWen : DmemRen) : ImemRen;
    assign w_d_elig   = ~r_served_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_acc_write  = 1'b0;
        w_acc_data   = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_d_elig && DmemWen) begin
                    w_accept    = 1'b1;
                    w_acc_write = 1'b1;
                    w_acc_data  = 1'b1;
                end else if (w_d_elig && DmemRen) begin
                    w_accept    = 1'b1;
                    w_acc_data  = 1'b1;
                end else if (ImemRen && !r_served_i) begin
                    w_accept    = 1'b1;
                end
                if (w_accept) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (!w_req_held) begin
                    w_next_state = IDLE;
                end else if (r_count == 8'd0) begin
                    w_next_state = DONE;
                    w_complete   = 1'b1;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request capture; these registers are only meaningful after an accept.
    always_ff @(posedge clock) begin
        if (w_accept && !reset) begin
            r_addr      <= w_acc_data ? DblockAddress : IblockAddr;
            r_write     <= w_acc_write;
            r_data_port <= w_acc_data;
            r_wdata     <= DmemDin;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count      <= 8'd0;
            r_served_i   <= 1'b0;
            r_served_d   <= 1'b0;
            r_imem_rdy   <= 1'b0;
            r_dmem_rdy   <= 1'b0;
            r_dmem_wdone <= 1'b0;
            r_imem_dout  <= '0;
            r_dmem_dout  <= '0;
        end else begin
            r_imem_rdy   <= 1'b0;
            r_dmem_rdy   <= 1'b0;
            r_dmem_wdone <= 1'b0;

            if (w_accept) begin
                r_count <= COUNT_LOAD;
            end else if (r_state == BUSY && r_count != 8'd0) begin
                r_count <= r_count - 8'd1;
            end

            // Pulses and read data are registered on the BUSY->DONE edge so
            // they are visible for exactly the DONE cycle.
            if (w_complete) begin
                if (r_write) begin
                    r_dmem_wdone <= 1'b1;
                end else if (r_data_port) begin
                    r_dmem_rdy  <= 1'b1;
                    r_dmem_dout <= r_mem[r_addr];
                end else begin
                    r_imem_rdy  <= 1'b1;
                    r_imem_dout <= r_mem[r_addr];
                end
            end

            // A completion cannot coincide with the request being low, so
            // set and clear never compete.
            if (w_complete && !r_data_port) begin
                r_served_i <= 1'b1;
            end else if (!ImemRen) begin
                r_served_i <= 1'b0;
            end

            if (w_complete && r_data_port) begin
                r_served_d <= 1'b1;
            end else if (!DmemRen && !DmemWen) begin
                r_served_d <= 1'b0;
            end
        end
    end

    // The write lands on the edge that closes DONE, so a reset raised during
    // DONE still suppresses it. Array contents survive reset.
    always_ff @(posedge clock) begin
        if (!reset && r_state == DONE && r_write) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign ImemDout      = r_imem_dout;
    assign DmemDout      = r_dmem_dout;
    assign ImemReadReady = r_imem_rdy;
    assign DmemReadReady = r_dmem_rdy;
    assign DmemWriteDone = r_dmem_wdone;

endmodule

// File: tb/tb_unified_block_memory.sv
module tb_unified_block_memory;

    localparam logic [2:0] K_IRD = 3'b100;
    localparam logic [2:0] K_DRD = 3'b010;
    localparam logic [2:0] K_WD  = 3'b001;

    localparam logic [127:0] PA5 = {16{8'hA5}};
    localparam logic [127:0] P6  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] P10 = {32{4'h1}};
    localparam logic [127:0] P20 = {32{4'h2}};
    localparam logic [127:0] PBAD = {16{8'hDE}};
    localparam logic [127:0] P3  = 128'hCAFEF00D_00000003_13579BDF_2468ACE0;

    typedef struct {
        logic [2:0]   kind;
        logic [127:0] data;
        int           at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    exp_t q4[$];
    exp_t q1[$];
    exp_t e4;
    exp_t e1;
    logic [2:0] pv4;
    logic [2:0] pv1;

    // DUT with LATENCY=4
    logic         a_iren = 1'b0, a_dren = 1'b0, a_dwen = 1'b0;
    logic [9:0]   a_iaddr = '0, a_daddr = '0;
    logic [127:0] a_ddin = '0;
    logic [127:0] a_idout, a_ddout;
    logic         a_irdy, a_drdy, a_dwd;

    // DUT with LATENCY=1
    logic         b_iren = 1'b0, b_dren = 1'b0, b_dwen = 1'b0;
    logic [3:0]   b_iaddr = '0, b_daddr = '0;
    logic [127:0] b_ddin = '0;
    logic [127:0] b_idout, b_ddout;
    logic         b_irdy, b_drdy, b_dwd;

    unified_block_memory #(.BLOCK_BITS(128), .ADDR_BITS(10), .LATENCY(4)) dut4 (
        .clock(clk), .reset(rst),
        .ImemRen(a_iren), .IblockAddr(a_iaddr), .ImemDout(a_idout), .ImemReadReady(a_irdy),
        .DmemRen(a_dren), .DmemWen(a_dwen), .DblockAddress(a_daddr), .DmemDin(a_ddin),
        .DmemDout(a_ddout), .DmemReadReady(a_drdy), .DmemWriteDone(a_dwd)
    );

    unified_block_memory #(.BLOCK_BITS(128), .ADDR_BITS(4), .LATENCY(1)) dut1 (
        .clock(clk), .reset(rst),
        .ImemRen(b_iren), .IblockAddr(b_iaddr), .ImemDout(b_idout), .ImemReadReady(b_irdy),
        .DmemRen(b_dren), .DmemWen(b_dwen), .DblockAddress(b_daddr), .DmemDin(b_ddin),
        .DmemDout(b_ddout), .DmemReadReady(b_drdy), .DmemWriteDone(b_dwd)
    );

    // Monitors: every completion pulse must match the head of the queue in
    // kind (one-hot, so overlapping pulses fail) and cycle; reads also in data.
    always @(negedge clk) begin
        pv4 = {a_irdy, a_drdy, a_dwd};
        if (pv4 != 3'b000) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL dut4_unexpected_pulse pulses=%b cyc=%0d", pv4, cyc);
            end else begin
                e4 = q4.pop_front();
                if (pv4 != e4.kind || cyc != e4.at) begin
                    errors++;
                    $display("FAIL dut4_pulse got=%b@%0d want=%b@%0d", pv4, cyc, e4.kind, e4.at);
                end
                if (e4.kind != K_WD) begin
                    checks++;
                    if ((e4.kind == K_IRD ? a_idout : a_ddout) !== e4.data) begin
                        errors++;
                        $display("FAIL dut4_rdata got=%h want=%h",
                                 (e4.kind == K_IRD ? a_idout : a_ddout), e4.data);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        pv1 = {b_irdy, b_drdy, b_dwd};
        if (pv1 != 3'b000) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected_pulse pulses=%b cyc=%0d", pv1, cyc);
            end else begin
                e1 = q1.pop_front();
                if (pv1 != e1.kind || cyc != e1.at) begin
                    errors++;
                    $display("FAIL dut1_pulse got=%b@%0d want=%b@%0d", pv1, cyc, e1.kind, e1.at);
                end
                if (e1.kind != K_WD) begin
                    checks++;
                    if ((e1.kind == K_IRD ? b_idout : b_ddout) !== e1.data) begin
                        errors++;
                        $display("FAIL dut1_rdata got=%h want=%h",
                                 (e1.kind == K_IRD ? b_idout : b_ddout), e1.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic wait_pulse(input int dut, input logic [2:0] which, input string tag);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (dut == 4 && ({a_irdy, a_drdy, a_dwd} & which) != 3'b000) return;
            if (dut == 1 && ({b_irdy, b_drdy, b_dwd} & which) != 3'b000) return;
        end
        checks++;
        errors++;
        $display("FAIL %s timeout got=none want=%b", tag, which);
    endtask

    // Raise a request while the DUT is IDLE; accepted on the next edge,
    // pulse expected LATENCY cycles after acceptance.
    task automatic push_exp(input int dut, input logic [2:0] kind, input logic [127:0] d, input int at);
        if (dut == 4) q4.push_back('{kind: kind, data: d, at: at});
        else          q1.push_back('{kind: kind, data: d, at: at});
    endtask

    task automatic d_op(input int dut, input logic wr, input logic [9:0] a,
                        input logic [127:0] din, input logic [127:0] exp_d, input string tag);
        if (dut == 4) begin
            a_daddr = a; a_ddin = din; a_dwen = wr; a_dren = ~wr;
        end else begin
            b_daddr = a[3:0]; b_ddin = din; b_dwen = wr; b_dren = ~wr;
        end
        push_exp(dut, wr ? K_WD : K_DRD, exp_d, cyc + 1 + dut);
        wait_pulse(dut, wr ? K_WD : K_DRD, tag);
        a_dwen = 1'b0; a_dren = 1'b0; b_dwen = 1'b0; b_dren = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic i_op(input int dut, input logic [9:0] a, input logic [127:0] exp_d, input string tag);
        if (dut == 4) begin a_iaddr = a; a_iren = 1'b1; end
        else          begin b_iaddr = a[3:0]; b_iren = 1'b1; end
        push_exp(dut, K_IRD, exp_d, cyc + 1 + dut);
        wait_pulse(dut, K_IRD, tag);
        a_iren = 1'b0; b_iren = 1'b0;
        @(posedge clk); #1;
    endtask

    int n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_imem_dout", a_idout, '0);
        chk("rst_dmem_dout", a_ddout, '0);
        chk("rst_pulses", {125'd0, a_irdy, a_drdy, a_dwd}, '0);
        rst = 1'b0;

        // write then read back at 0x005, plus preload of other addresses
        d_op(4, 1'b1, 10'h005, PA5, '0, "wr_005");
        d_op(4, 1'b0, 10'h005, '0, PA5, "rd_005");
        d_op(4, 1'b1, 10'h006, P6, '0, "wr_006");
        d_op(4, 1'b1, 10'h010, P10, '0, "wr_010");
        d_op(4, 1'b1, 10'h020, P20, '0, "wr_020");

        // simultaneous instr and data reads: data first, instr after
        n = cyc;
        a_iaddr = 10'h005; a_daddr = 10'h006; a_iren = 1'b1; a_dren = 1'b1;
        push_exp(4, K_DRD, P6, n + 5);
        push_exp(4, K_IRD, PA5, n + 11);
        wait_pulse(4, K_DRD, "prio_d");
        a_dren = 1'b0;
        wait_pulse(4, K_IRD, "prio_i");
        a_iren = 1'b0;
        @(posedge clk); #1;

        // instr request held past its pulse: one pulse, then re-request
        a_iaddr = 10'h006; a_iren = 1'b1;
        push_exp(4, K_IRD, P6, cyc + 5);
        wait_pulse(4, K_IRD, "hold_i1");
        repeat (3) begin @(posedge clk); #1; end
        a_iren = 1'b0;
        @(posedge clk); #1;
        a_iaddr = 10'h005; a_iren = 1'b1;
        push_exp(4, K_IRD, PA5, cyc + 5);
        wait_pulse(4, K_IRD, "hold_i2");
        a_iren = 1'b0;
        @(posedge clk); #1;

        // write to 0x010 dropped after two BUSY cycles: aborted
        a_daddr = 10'h010; a_ddin = PBAD; a_dwen = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        a_dwen = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        d_op(4, 1'b0, 10'h010, '0, P10, "abort_rd_010");
        chk("imem_dout_hold", a_idout, PA5);
        chk("dmem_dout_last", a_ddout, P10);

        // reset in the middle of a write to 0x020
        a_daddr = 10'h020; a_ddin = PBAD; a_dwen = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1; a_dwen = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("mid_rst_imem_dout", a_idout, '0);
        chk("mid_rst_dmem_dout", a_ddout, '0);
        chk("mid_rst_pulses", {125'd0, a_irdy, a_drdy, a_dwd}, '0);
        rst = 1'b0;
        d_op(4, 1'b0, 10'h020, '0, P20, "post_rst_rd_020");

        // LATENCY=1 instance
        d_op(1, 1'b1, 10'h003, P3, '0, "l1_wr_3");
        d_op(1, 1'b0, 10'h003, '0, P3, "l1_rd_3");
        i_op(1, 10'h003, P3, "l1_ird_3");
        chk("l1_dmem_dout_hold", b_ddout, P3);

        repeat (10) begin @(posedge clk); #1; end
        chk("queue4_drained", 128'(q4.size()), '0);
        chk("queue1_drained", 128'(q1.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
